result_collector: RTL and testbench
===================================

RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 Parameter DATA_W, default 16, width of one result element; payload carries two elements.
REQ-002 Parameter N_ROW, default 16, number of result rows.
REQ-003 Parameter N_COL, default 16, number of result columns; the frame holds N_ROW*N_COL = 256 elements in 128 beats.
REQ-004 Clocking: one clock; reset is asynchronous and active-high.
REQ-005 clk_data  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 result_valid_i  in  1  qualifies result_payload_i for one beat.
REQ-008 result_payload_i  in  32  [15:0] low element, [31:16] high element.
REQ-009 clear_i  in  1  synchronous frame clear or abort.
REQ-010 rd_en_i  in  1  read request.
REQ-011 rd_addr_i  in  8  linear element index (row*16 + col).
REQ-012 rd_valid_o  out  1  rd_data_o valid.
REQ-013 rd_data_o  out  16  element read back.
REQ-014 busy_o  out  1  high in COLLECT.
REQ-015 done_o  out  1  high in FULL.
REQ-016 overflow_o  out  1  sticky, set when a beat arrives in FULL.
REQ-017 beat_cnt_o  out  8  beats accepted in the current frame, 0..128.

Function
REQ-018 The FSM SHALL have states IDLE, COLLECT and FULL.
REQ-019 Beat b (0..127) SHALL map k = b[6:3] and i = b[2:0]; the low element goes to address {i,1'b0,k} = 32i+k and the high element to {i,1'b1,k} = 32i+16+k.
REQ-020 Storage SHALL be two 128x16 banks selected by address bit 4, so both elements of a beat are written in the same cycle.
REQ-021 IDLE: a valid beat SHALL be written as beat 0, set beat_cnt to 1 and move to COLLECT.
REQ-022 COLLECT: every valid beat SHALL be written and increment beat_cnt; no back-pressure exists, so every beat is accepted.
REQ-023 COLLECT: the beat that brings beat_cnt to 128 SHALL move the FSM to FULL on the same edge.
REQ-024 FULL: valid beats SHALL NOT be written; they SHALL set overflow_o and leave beat_cnt at 128.
REQ-025 clear_i in any state SHALL go to IDLE, zero beat_cnt and clear overflow_o; memory contents are kept.
REQ-026 clear_i together with result_valid_i: clear wins, the beat is dropped and overflow_o is not set.
REQ-027 Reads are allowed in every state: rd_en_i at cycle t gives rd_valid_o=1 and rd_data_o=mem[rd_addr_i] at t+1.
REQ-028 Any address 0..255 is valid; reading an unwritten element returns 0 after reset.
REQ-029 A read and a write to the same address in one cycle SHALL return the old data (read-before-write).
REQ-030 rd_data_o SHALL hold its last value while rd_valid_o=0.
REQ-031 Flag decode: busy_o = (state==COLLECT) and done_o = (state==FULL), both registered; no combinational path from inputs to outputs.

Reset
REQ-032 rst=1 SHALL force state IDLE, beat_cnt_o=0, overflow_o=0, busy_o=0, done_o=0, rd_valid_o=0 and rd_data_o=0, independent of clk_data.
REQ-033 Reset SHALL zero all 256 memory entries; a 128-cycle post-reset sweep is allowed, but busy_o stays 0 and beats arriving during the sweep SHALL still be written correctly.
REQ-034 Reset asserted mid-frame SHALL discard the frame; after deassertion the next valid beat is beat 0.

Verification
REQ-035 Full frame: send 128 beats with payload {16'(2b+1), 16'(2b)} -> done_o=1 at beat 128, beat_cnt_o=128; mem[32i+k]=2b and mem[32i+16+k]=2b+1 for b=8k+i.
REQ-036 Readback: after the frame, rd_en_i with rd_addr_i=0x11 -> next cycle rd_valid_o=1 and rd_data_o=0x0011 (b=8, high element).
REQ-037 Overflow: in FULL, send one beat 0xDEADBEEF -> overflow_o=1, beat_cnt_o stays 128, address 0 still reads 0x0000.
REQ-038 Clear collision: in FULL, assert clear_i and result_valid_i together -> IDLE, overflow_o=0, beat_cnt_o=0; the next beat 0x00050004 writes mem[0]=4 and mem[16]=5.
REQ-039 Mid-frame reset: assert rst after 40 beats -> all outputs 0 at once; a new 128-beat frame completes with done_o=1 and matches REQ-035.
REQ-040 Gapped input: 128 beats with random 0-3 idle cycles between them -> same memory image as REQ-035, busy_o high from beat 1 until done_o rises.

Source files
------------

// File: rtl/result_collector_if.sv
// Result-collector port bundle: beat input, frame clear, read port and status flags.
interface result_collector_if #(
    parameter int DATA_W = 16,
    parameter int N_ROW  = 16,
    parameter int N_COL  = 16
);
    localparam int AW = $clog2(N_ROW * N_COL);

    logic                  result_valid_i;
    logic [2*DATA_W-1:0]   result_payload_i;
    logic                  clear_i;
    logic                  rd_en_i;
    logic [AW-1:0]         rd_addr_i;
    logic                  rd_valid_o;
    logic [DATA_W-1:0]     rd_data_o;
    logic                  busy_o;
    logic                  done_o;
    logic                  overflow_o;
    logic [AW-1:0]         beat_cnt_o;

    modport master (
        output result_valid_i, result_payload_i, clear_i, rd_en_i, rd_addr_i,
        input  rd_valid_o, rd_data_o, busy_o, done_o, overflow_o, beat_cnt_o
    );

    modport slave (
        input  result_valid_i, result_payload_i, clear_i, rd_en_i, rd_addr_i,
        output rd_valid_o, rd_data_o, busy_o, done_o, overflow_o, beat_cnt_o
    );
endinterface

// File: rtl/result_collector.sv
// Collects a frame of two-element result beats into a transposed element store
// and serves single-element reads with one cycle of latency.
module result_collector #(
    parameter int DATA_W = 16,
    parameter int N_ROW  = 16,
    parameter int N_COL  = 16
) (
    input  logic             clk_data,
    input  logic             rst,
    result_collector_if.slave bus
);
    localparam int N_ELEM = N_ROW * N_COL;
    localparam int AW     = $clog2(N_ELEM);
    localparam int CW     = $clog2(N_COL);
    localparam int RW     = $clog2(N_ROW);
    localparam int BW     = AW - 1;
    localparam int N_BEAT = N_ELEM / 2;
    localparam logic [BW:0] LAST_BEAT = (BW+1)'(N_BEAT - 1);
    localparam logic [BW:0] CNT_ONE   = (BW+1)'(1);

    typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;

    state_t        state_q, state_d;
    logic [BW:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          wr_en;

    logic [DATA_W-1:0] bank_lo [N_BEAT];
    logic [DATA_W-1:0] bank_hi [N_BEAT];
    // Per-entry written flag stands in for zeroing the banks on reset.
    logic [N_BEAT-1:0] written_q;

    logic [BW-1:0]     wr_idx, rd_idx;
    logic              rd_bank;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;

    // Beat b = {k, i} lands at bank index {i, k}; address bit CW picks the bank.
    assign wr_idx  = {cnt_q[RW-2:0], cnt_q[BW-1:RW-1]};
    assign rd_idx  = {bus.rd_addr_i[AW-1:CW+1], bus.rd_addr_i[CW-1:0]};
    assign rd_bank = bus.rd_addr_i[CW];

    always_ff @(posedge clk_data or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        wr_en   = 1'b0;
        if (bus.clear_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.result_valid_i) begin
                        wr_en   = 1'b1;
                        cnt_d   = CNT_ONE;
                        state_d = COLLECT;
                    end
                end
                COLLECT: begin
                    if (bus.result_valid_i) begin
                        wr_en = 1'b1;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == LAST_BEAT) state_d = FULL;
                    end
                end
                FULL: begin
                    if (bus.result_valid_i) ovf_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_data) begin
        if (wr_en) begin
            bank_lo[wr_idx] <= bus.result_payload_i[DATA_W-1:0];
            bank_hi[wr_idx] <= bus.result_payload_i[2*DATA_W-1:DATA_W];
        end
    end

    always_ff @(posedge clk_data or posedge rst) begin
        if (rst) begin
            written_q <= '0;
        end else if (wr_en) begin
            written_q[wr_idx] <= 1'b1;
        end
    end

    // Read stage: samples the pre-write contents, so a same-cycle write is not visible.
    always_ff @(posedge clk_data or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= bus.rd_en_i;
            if (bus.rd_en_i) begin
                if (!written_q[rd_idx])
                    rd_data_q <= '0;
                else if (rd_bank)
                    rd_data_q <= bank_hi[rd_idx];
                else
                    rd_data_q <= bank_lo[rd_idx];
            end
        end
    end

    assign bus.rd_valid_o = rd_valid_q;
    assign bus.rd_data_o  = rd_data_q;
    assign bus.busy_o     = (state_q == COLLECT);
    assign bus.done_o     = (state_q == FULL);
    assign bus.overflow_o = ovf_q;
    assign bus.beat_cnt_o = cnt_q;
endmodule

// File: tb/tb_result_collector.sv
// Directed and randomized bench for result_collector with a frame-level reference model.
module tb_result_collector;
    localparam int DATA_W = 16;
    localparam int N_ROW  = 16;
    localparam int N_COL  = 16;

    logic clk_data = 1'b0;
    logic rst;

    result_collector_if #(.DATA_W(DATA_W), .N_ROW(N_ROW), .N_COL(N_COL)) bus ();

    result_collector #(.DATA_W(DATA_W), .N_ROW(N_ROW), .N_COL(N_COL)) dut (
        .clk_data (clk_data),
        .rst      (rst),
        .bus      (bus)
    );

    always #5 clk_data = ~clk_data;

    int checks = 0;
    int errors = 0;

    // Reference model: element image, accepted-beat count and sticky overflow.
    logic [15:0] exp_mem [256];
    int          exp_cnt;
    bit          exp_ovf;
    logic [15:0] last_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_cnt"},  32'(bus.beat_cnt_o), 32'(exp_cnt));
        check({tag, "_busy"}, 32'(bus.busy_o),     32'(exp_cnt > 0 && exp_cnt < 128));
        check({tag, "_done"}, 32'(bus.done_o),     32'(exp_cnt == 128));
        check({tag, "_ovf"},  32'(bus.overflow_o), 32'(exp_ovf));
    endtask

    task automatic model_reset();
        for (int a = 0; a < 256; a++) exp_mem[a] = 16'h0;
        exp_cnt = 0;
        exp_ovf = 1'b0;
        last_rd = 16'h0;
    endtask

    task automatic model_beat(input logic [31:0] payload, input bit clr);
        int b;
        if (clr) begin
            exp_cnt = 0;
            exp_ovf = 1'b0;
        end else if (exp_cnt == 128) begin
            exp_ovf = 1'b1;
        end else begin
            b = exp_cnt;
            exp_mem[32 * (b % 8) + (b / 8)]      = payload[15:0];
            exp_mem[32 * (b % 8) + 16 + (b / 8)] = payload[31:16];
            exp_cnt++;
        end
    endtask

    task automatic send_beat(input logic [31:0] payload, input bit clr, input string tag);
        bus.result_valid_i   = 1'b1;
        bus.result_payload_i = payload;
        bus.clear_i          = clr;
        @(posedge clk_data); #1;
        bus.result_valid_i   = 1'b0;
        bus.clear_i          = 1'b0;
        model_beat(payload, clr);
        check_flags(tag);
    endtask

    task automatic idle_cycle(input string tag);
        @(posedge clk_data); #1;
        check_flags(tag);
    endtask

    task automatic read_check(input int addr, input string tag);
        bus.rd_en_i   = 1'b1;
        bus.rd_addr_i = 8'(addr);
        @(posedge clk_data); #1;
        bus.rd_en_i = 1'b0;
        check({tag, "_rvld"}, 32'(bus.rd_valid_o), 32'd1);
        check({tag, "_rdat"}, 32'(bus.rd_data_o),  32'(exp_mem[addr]));
        last_rd = exp_mem[addr];
    endtask

    task automatic read_image(input string tag);
        for (int a = 0; a < 256; a++) read_check(a, tag);
    endtask

    initial begin
        rst                  = 1'b1;
        bus.result_valid_i   = 1'b0;
        bus.result_payload_i = '0;
        bus.clear_i          = 1'b0;
        bus.rd_en_i          = 1'b0;
        bus.rd_addr_i        = '0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk_data);
        #1;
        check_flags("rst");
        check("rst_rvld", 32'(bus.rd_valid_o), 32'd0);
        check("rst_rdat", 32'(bus.rd_data_o),  32'd0);
        @(negedge clk_data);
        rst = 1'b0;
        @(posedge clk_data); #1;
        read_check(8'h11, "unwritten");
        read_check(8'hff, "unwritten_top");

        // Full back-to-back frame straight out of reset
        for (int b = 0; b < 128; b++)
            send_beat({16'(2 * b + 1), 16'(2 * b)}, 1'b0, "frame1");
        read_image("img1");
        read_check(8'h11, "rd_0x11");
        check("rd_0x11_const", 32'(bus.rd_data_o), 32'h0011);
        idle_cycle("hold");
        check("hold_rvld", 32'(bus.rd_valid_o), 32'd0);
        check("hold_rdat", 32'(bus.rd_data_o),  32'(last_rd));

        // Overflow in FULL
        send_beat(32'hDEADBEEF, 1'b0, "ovf");
        idle_cycle("ovf_sticky");
        read_check(0, "ovf_addr0");
        check("ovf_addr0_const", 32'(bus.rd_data_o), 32'h0000);

        // Clear colliding with a beat, then read-before-write on address 16
        send_beat(32'h12345678, 1'b1, "clr_coll");
        bus.rd_en_i   = 1'b1;
        bus.rd_addr_i = 8'd16;
        last_rd = exp_mem[16];
        send_beat(32'h00050004, 1'b0, "post_clr");
        bus.rd_en_i = 1'b0;
        check("rbw_rvld", 32'(bus.rd_valid_o), 32'd1);
        check("rbw_rdat", 32'(bus.rd_data_o),  32'(last_rd));
        read_check(0, "post_clr_m0");
        check("m0_const", 32'(bus.rd_data_o), 32'h0004);
        read_check(16, "post_clr_m16");
        check("m16_const", 32'(bus.rd_data_o), 32'h0005);

        // Random partial frame, then asynchronous reset mid-frame
        for (int b = 1; b < 40; b++)
            send_beat($urandom, 1'b0, "rand40");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_flags("midrst");
        check("midrst_rvld", 32'(bus.rd_valid_o), 32'd0);
        check("midrst_rdat", 32'(bus.rd_data_o),  32'd0);
        @(negedge clk_data);
        rst = 1'b0;
        @(posedge clk_data); #1;
        read_check(16, "cleared_m16");
        read_check(32 * 3 + 4, "cleared_b35");

        // Gapped frame after reset: same image as the back-to-back frame
        for (int b = 0; b < 128; b++) begin
            send_beat({16'(2 * b + 1), 16'(2 * b)}, 1'b0, "gapped");
            for (int g = $urandom_range(3, 0); g > 0; g--)
                idle_cycle("gap");
        end
        read_image("img2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
